led_mode_ctrl: RTL and testbench

- Key-driven LED mode controller, directly downstream of breath_led.
- Debounces one push-button and cycles the LED mode OFF -> ON -> BLINK -> BREATH -> OFF on each short press; a long press forces OFF.
- In BREATH mode it passes breath_led's PWM output (breath_in) through to the pin.
- Drives the final board LED pin and exports breath_en for gating the breathing stage.

---
 rtl/led_pkg.sv | 29 ++
 rtl/led_mode_ctrl_if.sv | 13 +
 rtl/key_filter.sv | 59 +++++
 rtl/led_mode_ctrl.sv | 119 +++++++++++
 tb/tb_led_mode_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared mode encodings and 50 MHz timing constants for the LED control path.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BREATH = 2'd3
  } mode_t;

  localparam int unsigned CNT_20MS_W  = 20;
  localparam int unsigned CNT_BLINK_W = 25;
  localparam int unsigned CNT_LONG_W  = 27;

  localparam logic [CNT_20MS_W-1:0]  CNT_20MS_MAX_DEF  = 20'd999_999;
  localparam logic [CNT_BLINK_W-1:0] CNT_BLINK_MAX_DEF = 25'd24_999_999;
  localparam logic [CNT_LONG_W-1:0]  CNT_LONG_MAX_DEF  = 27'd99_999_999;

  // Short-press mode sequence OFF -> ON -> BLINK -> BREATH -> OFF.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:    return MODE_ON;
      MODE_ON:     return MODE_BLINK;
      MODE_BLINK:  return MODE_BREATH;
      default:     return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// Key, PWM and LED pin bundle between the board side and led_mode_ctrl.
interface led_mode_ctrl_if;
  import led_pkg::*;

  logic  key_in;
  logic  breath_in;
  logic  led_out;
  logic  breath_en;
  mode_t mode;

  modport slave  (input key_in, breath_in, output led_out, breath_en, mode);
  modport master (output key_in, breath_in, input led_out, breath_en, mode);
endinterface

// File: rtl/key_filter.sv
// Push-button synchronizer and debouncer with one-cycle press/release pulses.
module key_filter
  import led_pkg::*;
#(
  parameter logic [CNT_20MS_W-1:0] CNT_20MS_MAX = CNT_20MS_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_stable,
  output logic press_flag,
  output logic release_flag
);

  logic                  key_meta;
  logic                  key_sync;
  logic                  key_prev;
  logic [CNT_20MS_W-1:0] key_cnt;

  // Two-flop synchronizer; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
    end
  end

  // Accept a new level only after CNT_20MS_MAX+1 consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_cnt    <= '0;
      key_stable <= 1'b1;
    end else if (key_sync == key_stable) begin
      key_cnt <= '0;
    end else if (key_cnt == CNT_20MS_MAX) begin
      key_stable <= key_sync;
      key_cnt    <= '0;
    end else begin
      key_cnt <= key_cnt + CNT_20MS_W'(1);
    end
  end

  // Edge pulses on the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev     <= 1'b1;
      press_flag   <= 1'b0;
      release_flag <= 1'b0;
    end else begin
      key_prev     <= key_stable;
      press_flag   <= key_prev & ~key_stable;
      release_flag <= ~key_prev & key_stable;
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// Key-driven LED mode controller: short press cycles the mode, long press forces OFF.
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter logic [CNT_20MS_W-1:0]  CNT_20MS_MAX  = CNT_20MS_MAX_DEF,
  parameter logic [CNT_BLINK_W-1:0] CNT_BLINK_MAX = CNT_BLINK_MAX_DEF,
  parameter logic [CNT_LONG_W-1:0]  CNT_LONG_MAX  = CNT_LONG_MAX_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  led_mode_ctrl_if.slave     bus
);

  logic                   key_stable;
  logic                   press_flag;
  logic                   release_flag;
  logic                   pressed;
  logic [CNT_LONG_W-1:0]  hold_cnt;
  logic                   long_flag;
  logic                   short_flag_c;
  mode_t                  mode_q;
  mode_t                  mode_d;
  logic                   breath_en_d;
  logic                   breath_en_q;
  logic [CNT_BLINK_W-1:0] blink_cnt;
  logic                   blink_lvl;
  logic                   led_q;

  key_filter #(
    .CNT_20MS_MAX (CNT_20MS_MAX)
  ) u_key_filter (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .key_in       (bus.key_in),
    .key_stable   (key_stable),
    .press_flag   (press_flag),
    .release_flag (release_flag)
  );

  // Tracks an open press so a release is only honoured after its press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)        pressed <= 1'b0;
    else if (press_flag)   pressed <= 1'b1;
    else if (release_flag) pressed <= 1'b0;
  end

  // Stable-press duration, saturating; long_flag pulses once when it saturates.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt  <= '0;
      long_flag <= 1'b0;
    end else begin
      long_flag <= ~key_stable && (hold_cnt == CNT_LONG_MAX - CNT_LONG_W'(1));
      if (release_flag)
        hold_cnt <= '0;
      else if (!key_stable && hold_cnt != CNT_LONG_MAX)
        hold_cnt <= hold_cnt + CNT_LONG_W'(1);
    end
  end

  assign short_flag_c = release_flag && pressed && (hold_cnt < CNT_LONG_MAX);

  // Mode state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q      <= MODE_OFF;
      breath_en_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      breath_en_q <= breath_en_d;
    end
  end

  // Next mode from press flags; breath_en follows the next mode.
  always_comb begin
    mode_d      = mode_q;
    breath_en_d = 1'b0;
    if (long_flag)
      mode_d = MODE_OFF;
    else if (short_flag_c)
      mode_d = next_mode(mode_q);
    breath_en_d = (mode_d == MODE_BREATH);
  end

  // Blink half-period generator; parked lit outside BLINK so entry starts lit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blink_cnt <= '0;
      blink_lvl <= 1'b1;
    end else if (mode_q != MODE_BLINK) begin
      blink_cnt <= '0;
      blink_lvl <= 1'b1;
    end else if (blink_cnt == CNT_BLINK_MAX) begin
      blink_cnt <= '0;
      blink_lvl <= ~blink_lvl;
    end else begin
      blink_cnt <= blink_cnt + CNT_BLINK_W'(1);
    end
  end

  // Registered LED pin mux.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q <= 1'b0;
    end else begin
      case (mode_q)
        MODE_OFF:   led_q <= 1'b0;
        MODE_ON:    led_q <= 1'b1;
        MODE_BLINK: led_q <= blink_lvl;
        default:    led_q <= bus.breath_in;
      endcase
    end
  end

  assign bus.led_out   = led_q;
  assign bus.breath_en = breath_en_q;
  assign bus.mode      = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with an event-level reference model.
module tb_led_mode_ctrl;

  localparam int D = 4;
  localparam int B = 3;
  localparam int L = 20;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  bit   cmp_en    = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  led_mode_ctrl_if bus ();

  led_mode_ctrl #(
    .CNT_20MS_MAX  (20'(D)),
    .CNT_BLINK_MAX (25'(B)),
    .CNT_LONG_MAX  (27'(L))
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic short_press();
    bus.key_in = 1'b0;
    tick(12);
    bus.key_in = 1'b1;
    tick(15);
  endtask

  // Reference model: debounced level changes become scheduled mode events.
  int cyc      = 0;
  bit m_s1     = 1'b1;
  bit m_s2     = 1'b1;
  bit m_stab   = 1'b1;
  int m_run    = 0;
  int m_press  = 0;
  int m_mode   = 0;
  int m_bstart = 0;
  bit m_led    = 1'b0;
  bit m_ben    = 1'b0;
  int ev_short = -1;
  int ev_long  = -1;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_stab = 1'b1; m_run = 0;
      m_mode = 0; m_led = 1'b0; m_ben = 1'b0;
      ev_short = -1; ev_long = -1;
    end else begin
      cyc++;
      case (m_mode)
        0:       m_led = 1'b0;
        1:       m_led = 1'b1;
        2:       m_led = (((cyc - 1 - m_bstart) / (B + 1)) % 2) == 0;
        default: m_led = bus.breath_in;
      endcase
      if (m_s2 != m_stab) begin
        m_run++;
        if (m_run == D + 1) begin
          m_stab = m_s2;
          m_run  = 0;
          if (!m_stab) begin
            m_press = cyc;
            ev_long = cyc + L + 1;
          end else if (cyc - m_press < L) begin
            ev_long  = -1;
            ev_short = cyc + 2;
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = bus.key_in;
      if (cyc == ev_long) begin
        m_mode  = 0;
        ev_long = -1;
      end
      if (cyc == ev_short) begin
        m_mode = (m_mode + 1) % 4;
        if (m_mode == 2) m_bstart = cyc;
        ev_short = -1;
      end
      m_ben = (m_mode == 3);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    if (cmp_en) begin
      check("led_out", bus.led_out, m_led);
      check("mode", bus.mode, m_mode);
      check("breath_en", bus.breath_en, m_ben);
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  bit blink_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  bit breath_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    bus.key_in    = 1'b1;
    bus.breath_in = 1'b0;
    cmp_en        = 1'b1;
    #200;
    sys_rst_n = 1'b1;

    // Idle after reset
    tick(100);
    check("idle_mode", bus.mode, 0);
    check("idle_led", bus.led_out, 0);
    check("idle_ben", bus.breath_en, 0);

    // Glitch shorter than the debounce window
    bus.key_in = 1'b0;
    tick(3);
    bus.key_in = 1'b1;
    tick(20);
    check("glitch_mode", bus.mode, 0);

    // First short press: exact latency from the release edge
    bus.key_in = 1'b0;
    tick(12);
    bus.key_in = 1'b1;
    tick(8);
    check("t3_mode_before", bus.mode, 0);
    tick(1);
    check("t3_mode_on", bus.mode, 1);
    check("t3_led_lag", bus.led_out, 0);
    tick(1);
    check("t3_led_on", bus.led_out, 1);

    // Second press: BLINK pattern
    tick(10);
    bus.key_in = 1'b0;
    tick(12);
    bus.key_in = 1'b1;
    tick(9);
    check("t4_mode_blink", bus.mode, 2);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      check("t4_blink_pat", bus.led_out, blink_pat[i % 8]);
    end

    // Third press: BREATH passthrough
    bus.key_in = 1'b0;
    tick(12);
    bus.key_in = 1'b1;
    tick(9);
    check("t4_mode_breath", bus.mode, 3);
    check("t4_ben_on", bus.breath_en, 1);
    for (int i = 0; i < 5; i++) begin
      bus.breath_in = breath_pat[i];
      tick(1);
      check("t4_breath_pat", bus.led_out, breath_pat[i]);
    end
    bus.breath_in = 1'b0;

    // Fourth press: back to OFF
    tick(5);
    bus.key_in = 1'b0;
    tick(12);
    bus.key_in = 1'b1;
    tick(9);
    check("t4_mode_off", bus.mode, 0);
    check("t4_ben_off", bus.breath_en, 0);
    tick(1);
    check("t4_led_off", bus.led_out, 0);

    // Long press from BLINK forces OFF; release does not advance
    tick(5);
    short_press();
    short_press();
    check("t5_mode_blink", bus.mode, 2);
    bus.key_in = 1'b0;
    tick(27);
    check("t5_mode_pre_long", bus.mode, 2);
    tick(1);
    check("t5_mode_long_off", bus.mode, 0);
    tick(12);
    bus.key_in = 1'b1;
    tick(30);
    check("t5_mode_after_rel", bus.mode, 0);
    check("t5_led_after_rel", bus.led_out, 0);

    // Asynchronous reset in the middle of BLINK
    short_press();
    short_press();
    check("t6_mode_blink", bus.mode, 2);
    tick(1);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #2;
    check("t6_rst_led", bus.led_out, 0);
    check("t6_rst_mode", bus.mode, 0);
    check("t6_rst_ben", bus.breath_en, 0);
    tick(3);
    sys_rst_n = 1'b1;
    tick(30);
    check("t6_post_mode", bus.mode, 0);
    check("t6_post_led", bus.led_out, 0);
    short_press();
    check("t6_fresh_mode", bus.mode, 1);
    check("t6_fresh_led", bus.led_out, 1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
